// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift unit.
//   WIDTH_DEF      : default operand width
//   MODE_*         : shift mode encodings carried on in_mode
//   state_t        : control FSM states
package shift_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SLL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// Single-stride shifter: applies a shift of 2^stage in the selected mode.
// Purely combinational; the top steps "stage" down one per clock.
//   din   : value to shift
//   stage : stride exponent (stride = 2^stage)
//   apply : 1 = shift, 0 = pass din through
//   mode  : MODE_SLL shifts left, anything else shifts right
//   fill  : bit shifted in from the top on right shifts
//   dout  : result
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] stage,
  input  logic               apply,
  input  logic [1:0]         mode,
  input  logic               fill,
  output logic [WIDTH-1:0]   dout
);

  logic [SHAMT_W-1:0] stride;
  logic [WIDTH-1:0]   fill_mask;

  // stage <= SHAMT_W-1, so 2^stage <= WIDTH/2 always fits in SHAMT_W bits.
  assign stride    = SHAMT_W'(1) << stage;
  // Ones in exactly the top 'stride' bit positions vacated by a right shift.
  assign fill_mask = ~({WIDTH{1'b1}} >> stride);

  always_comb begin
    dout = din;
    if (apply) begin
      if (mode == MODE_SLL) dout = din << stride;
      else                  dout = (din >> stride) | (fill ? fill_mask : '0);
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle variable shift unit (sll/srl/sra and variable forms).
// The amount is decomposed into strides 2^(SHAMT_W-1) .. 1, one per clock,
// so a normal request always takes SHAMT_W cycles regardless of amount.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : request handshake (ready only while IDLE)
//   in_a, in_shamt      : operand and shift amount
//   in_mode             : 00 srl, 01 sll, 10 sra, 11 reserved (result 0)
//   in_enable           : 0 = bypass, result is in_a
//   out_valid/out_ready : result handshake (valid only while DONE)
//   out_b               : result, held stable while DONE
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic               in_enable,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_b
);

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] shamt_q;
  logic [SHAMT_W-1:0] stage;
  logic [1:0]         mode_q;
  logic               sign_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  shift_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_stage (
    .din   (work),
    .stage (stage),
    .apply (shamt_q[stage]),
    .mode  (mode_q),
    .fill  (sign_q & (mode_q == MODE_SRA)),
    .dout  (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      work    <= '0;
      shamt_q <= '0;
      stage   <= '0;
      mode_q  <= MODE_SRL;
      sign_q  <= 1'b0;
      out_b   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shamt_q <= in_shamt;
          mode_q  <= in_mode;
          sign_q  <= in_a[WIDTH-1];
          if (!in_enable) begin
            out_b <= in_a;
            state <= DONE;
          end else if (in_mode == MODE_RSV) begin
            out_b <= '0;
            state <= DONE;
          end else begin
            work  <= in_a;
            stage <= SHAMT_W'(SHAMT_W - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= shifted;
          if (stage == '0) begin
            out_b <= shifted;
            state <= DONE;
          end else begin
            stage <= stage - SHAMT_W'(1);
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Multi-cycle, variable-amount shift unit for the MIPS execute stage. It serves sll/srl/sra and the variable forms (sllv/srlv/srav).
- Takes an operand and a 5-bit shift amount through a valid/ready handshake.
- Decomposes the amount into fixed power-of-two strides (16, 8, 4, 2, 1) and applies one stride per clock.
- Returns the result through a second valid/ready handshake. It is the sequential counterpart of the fixed-distance combinational shifter.

Parameters:
- WIDTH, 32, operand width. Must be a power of two, at least 2.
- SHAMT_W, $clog2(WIDTH), shift-amount width. This is also the number of stride cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_a  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount.
- in_mode  in  2  00 logical right, 01 logical left, 10 arithmetic right, 11 reserved.
- in_enable  in  1  0 = bypass: result equals in_a.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_b  out  WIDTH  result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, out_b=0.
  - Internal operand, amount, mode and stage counter cleared.
  - Takes effect immediately, including mid-operation. Any in-flight request is discarded, with no partial result.
- States: IDLE, SHIFT, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- Acceptance: at a rising edge with state=IDLE and in_valid=1. The unit captures in_a, in_shamt, in_mode, in_enable, and the sign bit in_a[WIDTH-1].
  - in_enable=0: out_b<=in_a, go to DONE (out_valid the cycle after acceptance).
  - in_mode=11 (with in_enable=1): out_b<=0, go to DONE.
  - Otherwise: work register<=in_a, stage<=SHAMT_W-1, go to SHIFT.
- SHIFT, each edge:
  - If shamt[stage]=1, shift the work register by 2^stage in the captured mode; otherwise hold it.
  - Right logical fills with 0. Left fills with 0. Arithmetic right fills with the captured sign bit.
  - If stage=0: out_b<=shifted value, go to DONE. Otherwise stage<=stage-1.
- Latency:
  - Normal path: out_valid rises exactly SHAMT_W cycles after the acceptance edge (5 for WIDTH=32), independent of the shamt value, including shamt=0.
  - Bypass and reserved paths: 1 cycle.
- DONE: out_b and out_valid are held stable until out_valid&&out_ready at an edge; then go to IDLE.
  - in_ready returns the cycle after the handshake. There is no same-edge re-accept.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE; inputs need not be held after acceptance.
- shamt=WIDTH-1 is the maximum. There is no wrap and no modulo beyond the SHAMT_W-bit field.
- out_b changes only on entry to DONE or on reset.

Decomposition:
- Package shift_pkg holds:
  - mode constants MODE_SRL=2'b00, MODE_SLL=2'b01, MODE_SRA=2'b10, MODE_RSV=2'b11;
  - the state enum (IDLE, SHIFT, DONE);
  - the default WIDTH.
- One natural sub-module: shift_stage. It is combinational and applies a single runtime-selected stride 2^stage in the given mode with a sign-fill input. It is instantiated once and driven by the stage counter.

Test Plan:
- srl: a=0x80000000, shamt=4, mode=00, enable=1 -> out_valid 5 cycles after accept, out_b=0x08000000.
- sra: a=0x80000000, shamt=4, mode=10 -> 0xF8000000. Also a=0x7FFFFFF0, shamt=4, mode=10 -> 0x07FFFFFF.
- sll with max amount and zero amount:
  - a=0x00000001, shamt=31, mode=01 -> 0x80000000 after 5 cycles.
  - shamt=0 -> out_b=in_a, still 5 cycles.
- Bypass and reserved:
  - enable=0, a=0xDEADBEEF -> out_b=0xDEADBEEF after 1 cycle.
  - mode=11, enable=1 -> out_b=0 after 1 cycle.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_b stable, in_ready=0, in_valid ignored. Raise out_ready -> handshake; in_ready=1 the next cycle; a back-to-back request is accepted then.
- Reset mid-operation: assert rst_n=0 during cycle 3 of SHIFT -> immediately in_ready=1, out_valid=0, out_b=0. After release, a new request completes correctly with no stale data.
